// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode and FSM state encodings shared by the decode and exec stages
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
// alu_mul_seq : unsigned shift-add multiplier, one partial product per cycle
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     sum_w;
  logic [2*WIDTH-1:0] acc_d;

  // Low half of acc holds the remaining multiplier bits; they shift out as the product shifts in.
  assign sum_w     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_d     = {sum_w, acc_q[WIDTH-1:1]};
  assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      mcand_q <= a_i;
      acc_q   <= {{WIDTH{1'b0}}, b_i};
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec.sv
// ============================================================================
// alu_exec : multi-cycle ALU execution unit with valid/ready in and out.
//            Define ALU_MUL_EN to include the sequential multiplier.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_illegal
);

  localparam int SW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             illegal_q, illegal_d;

  logic [SW-1:0]    amt_w;
  logic [WIDTH:0]   add_w;
  logic [WIDTH-1:0] shifted_w;

  assign amt_w     = operand_b[SW-1:0];
  assign add_w     = {1'b0, operand_a} + {1'b0, operand_b};
  assign shifted_w = (op_q == OP_SHL) ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

`ifdef ALU_MUL_EN
  logic               mul_done_w;
  logic [2*WIDTH-1:0] mul_prod_w;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (in_valid && (state_q == ST_IDLE) && (alu_op == OP_MUL)),
    .a_i       (operand_a),
    .b_i       (operand_b),
    .done_o    (mul_done_w),
    .product_o (mul_prod_w)
  );
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d      = alu_op;
          sh_d      = operand_a;
          cnt_d     = amt_w;
          carry_d   = 1'b0;
          illegal_d = 1'b0;
          state_d   = ST_DONE;
          case (alu_op)
            OP_ADD: begin
              result_d = add_w[WIDTH-1:0];
              carry_d  = add_w[WIDTH];
            end
            OP_SUB: begin
              result_d = operand_a - operand_b;
              carry_d  = (operand_a < operand_b);
            end
            OP_AND: result_d = operand_a & operand_b;
            OP_OR:  result_d = operand_a | operand_b;
            OP_XOR: result_d = operand_a ^ operand_b;
            OP_SHL, OP_SHR: begin
              if (amt_w == '0) result_d = operand_a;
              else             state_d  = ST_BUSY;
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
              state_d = ST_BUSY;
`else
              result_d  = '0;
              illegal_d = 1'b1;
`endif
            end
            default: result_d = '0;
          endcase
        end
      end

      ST_BUSY: begin
`ifdef ALU_MUL_EN
        if (op_q == OP_MUL) begin
          if (mul_done_w) begin
            result_d = mul_prod_w[WIDTH-1:0];
            carry_d  = |mul_prod_w[2*WIDTH-1:WIDTH];
            state_d  = ST_DONE;
          end
        end else
`endif
        begin
          // Carry tracks the bit leaving the operand, so the last step leaves the final one.
          carry_d = (op_q == OP_SHL) ? sh_q[WIDTH-1] : sh_q[0];
          sh_d    = shifted_w;
          cnt_d   = cnt_q - SW'(1);
          if (cnt_q == SW'(1)) begin
            result_d = shifted_w;
            state_d  = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE && state_q != ST_DONE) zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      sh_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_DONE);
  assign result       = result_q;
  assign flag_zero    = zero_q;
  assign flag_carry   = carry_q;
  assign flag_illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// tb_alu_exec : directed scoreboard bench for alu_exec (WIDTH = 16)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    alu_op = 3'd0;
  logic [W-1:0]  operand_a = '0;
  logic [W-1:0]  operand_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          flag_zero;
  logic          flag_carry;
  logic          flag_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         ill;
    int           lat;
  } exp_t;

  exp_t sb[$];

  alu_exec #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op       (alu_op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .flag_illegal (flag_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    int             n;
    n = int'(b[3:0]);
    e.c = 1'b0; e.ill = 1'b0; e.lat = 1; e.res = '0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[W-1:0]; e.c = s[W]; end
      3'd1: begin e.res = a - b; e.c = (a < b); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin
        e.res = a << n;
        if (n > 0) begin e.c = a[W-n]; e.lat = n + 1; end
      end
      3'd6: begin
        e.res = a >> n;
        if (n > 0) begin e.c = a[n-1]; e.lat = n + 1; end
      end
      default: begin
`ifdef ALU_MUL_EN
        p = a * b;
        e.res = p[W-1:0];
        e.c = |p[2*W-1:W];
        e.lat = W + 1;
`else
        p = '0;
        e.ill = 1'b1;
`endif
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; alu_op = op; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    operand_a = W'($urandom); operand_b = W'($urandom); alu_op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("result", 32'(result), 32'(e.res));
    check("zero", 32'(flag_zero), 32'(e.z));
    check("carry", 32'(flag_carry), 32'(e.c));
    check("illegal", 32'(flag_illegal), 32'(e.ill));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_result", {12'd0, flag_illegal, flag_carry, flag_zero, result},
            {12'd0, e.ill, e.c, e.z, e.res});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_consume", 32'(in_ready), 32'd1);
    check("out_valid_after_consume", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen_valid;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_flags", {29'd0, flag_zero, flag_carry, flag_illegal}, 32'd0);

    run_op(3'd0, 16'hFFFF, 16'h0001, 0);
    run_op(3'd1, 16'h0003, 16'h0005, 0);
    run_op(3'd2, 16'hF0F0, 16'h3C3C, 0);
    run_op(3'd3, 16'hF000, 16'h000F, 0);
    run_op(3'd4, 16'hAAAA, 16'hAAAA, 0);
    run_op(3'd5, 16'h8001, 16'h0001, 0);
    run_op(3'd6, 16'h1234, 16'h0000, 0);
    run_op(3'd6, 16'hC001, 16'h000F, 0);
    run_op(3'd5, 16'h1235, 16'h0013, 0);
    run_op(3'd7, 16'h0100, 16'h0100, 0);
    run_op(3'd7, 16'h0003, 16'h0005, 0);
    run_op(3'd0, 16'h1234, 16'h0F0F, 5);

    // Reset on the 8th BUSY cycle of a long operation
    @(negedge clk);
    in_valid = 1'b1;
`ifdef ALU_MUL_EN
    alu_op = 3'd7; operand_a = 16'h0100; operand_b = 16'h0100;
`else
    alu_op = 3'd5; operand_a = 16'h0001; operand_b = 16'h000F;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("busy_no_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_result", 32'(result), 32'd0);
    seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1;
    end
    check("rst_mid_never_valid", 32'(seen_valid), 32'd0);
    run_op(3'd0, 16'h0002, 16'h0002, 0);

    for (int k = 0; k < 8; k++) begin
      run_op(3'($urandom), W'($urandom), W'($urandom), k % 2);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
